demux8_1_reg: RTL and testbench

Registered 1-to-8 demultiplexer and bit deserializer: the write side of the 8:1 bit-select path. Each cycle it steers one input bit into one of eight held output bits. The destination is either an explicit 3-bit select (addressed write) or an internal auto-incrementing pointer (streaming write). A streaming sequence of eight bits therefore reassembles the word that the 8:1 mux serializes when its select counts 0..7. It sits between the datapath bit-serial links and any consumer that needs the parallel byte.

---
 rtl/demux_pkg.sv | 7 +
 rtl/decoder3_8.sv | 13 +
 rtl/demux8_1_reg.sv | 65 ++++++
 tb/tb_demux8_1_reg.sv | 121 ++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// Shared widths and types for the registered 1-to-8 bit demultiplexer.
package demux_pkg;
  localparam int SEL_W  = 3;
  localparam int WORD_W = 2**SEL_W;
  typedef logic [WORD_W-1:0] word_t;
  typedef logic [SEL_W-1:0]  idx_t;
endpackage

// File: rtl/decoder3_8.sv
// Combinational one-hot decode of a bit index, gated by an enable.
module decoder3_8
  import demux_pkg::*;
(
  input  idx_t  idx,
  input  logic  en,
  output word_t onehot
);
  always_comb begin
    onehot = '0;
    if (en) onehot[idx] = 1'b1;
  end
endmodule

// File: rtl/demux8_1_reg.sv
// Registered 1-to-8 demux / bit deserializer: addressed writes via sel,
// streaming writes via an auto-incrementing pointer.
module demux8_1_reg
  import demux_pkg::*;
#(
  parameter int SEL_W = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  din,
  input  logic [SEL_W-1:0]      sel,
  input  logic                  wr,
  input  logic                  shift,
  input  logic                  clr,
  output logic [2**SEL_W-1:0]   out,
  output logic [SEL_W-1:0]      ptr,
  output logic                  done,
  output logic                  all_set,
  output logic                  err
);
  localparam int W = 2**SEL_W;

  logic [SEL_W-1:0] ptr_q, idx;
  logic [W-1:0]     mask_q, dec;
  logic             done_q, err_q, kill, stream, last;

  assign kill   = reset | clr;
  // wr wins a collision; the shift is dropped and ptr holds
  assign stream = shift & ~wr;
  assign last   = stream & (ptr_q == '1);
  assign idx    = wr ? sel : ptr_q;

  decoder3_8 u_dec (
    .idx    (idx),
    .en     (wr | shift),
    .onehot (dec)
  );

  for (genvar k = 0; k < W; k++) begin : g_bit
    always_ff @(posedge clk) begin
      if (kill)        out[k] <= 1'b0;
      else if (dec[k]) out[k] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (kill) begin
      ptr_q  <= '0;
      mask_q <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      if (stream) ptr_q <= ptr_q + 1'b1;
      // completing a word restarts the coverage mask; out keeps the word
      mask_q <= last ? '0 : (mask_q | dec);
      done_q <= last;
      err_q  <= wr & shift;
    end
  end

  assign ptr     = ptr_q;
  assign done    = done_q;
  assign err     = err_q;
  assign all_set = &mask_q;
endmodule

// File: tb/tb_demux8_1_reg.sv
// Self-checking bench: directed steps plus random traffic against a behavioural model.
module tb_demux8_1_reg;
  logic       clk = 1'b0;
  logic       reset = 1'b1, din = 1'b0, wr = 1'b0, shift = 1'b0, clr = 1'b0;
  logic [2:0] sel = 3'd0;
  logic [7:0] out;
  logic [2:0] ptr;
  logic       done, all_set, err;

  int n_vec = 0;
  int n_err = 0;

  bit [7:0] m_out, m_mask;
  int       m_ptr;
  bit       m_done, m_err;

  always #5 clk = ~clk;

  demux8_1_reg #(.SEL_W(3)) dut (
    .clk(clk), .reset(reset), .din(din), .sel(sel), .wr(wr), .shift(shift),
    .clr(clr), .out(out), .ptr(ptr), .done(done), .all_set(all_set), .err(err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // one clock: drive at negedge, update model at posedge, check 1ns later
  task automatic step(input logic r, input logic c, input logic w, input logic s,
                      input logic d, input logic [2:0] sl);
    @(negedge clk);
    reset = r; clr = c; wr = w; shift = s; din = d; sel = sl;
    @(posedge clk);
    if (r || c) begin
      m_out = 0; m_mask = 0; m_ptr = 0; m_done = 0; m_err = 0;
    end else begin
      m_err  = w && s;
      m_done = 0;
      if (w) begin
        m_out[sl] = d; m_mask[sl] = 1'b1;
      end else if (s) begin
        m_out[m_ptr] = d; m_mask[m_ptr] = 1'b1;
        if (m_ptr == 7) begin m_done = 1; m_mask = 0; end
        m_ptr = (m_ptr + 1) % 8;
      end
    end
    #1;
    chk("out", out, m_out);
    chk("ptr", ptr, m_ptr);
    chk("done", done, m_done);
    chk("all_set", all_set, m_mask == 8'hFF);
    chk("err", err, m_err);
  endtask

  initial begin : main
    logic [7:0] pat, v;
    int dones;
    m_out = 0; m_mask = 0; m_ptr = 0; m_done = 0; m_err = 0;

    // reset dominates active strobes
    step(1, 0, 1, 1, 1, 3'd7);
    step(1, 0, 1, 1, 1, 3'd7);
    chk("reset_out", out, 8'h00);

    // streaming word, LSB first
    pat = 8'b0100_1101;
    for (int k = 0; k < 8; k++) step(0, 0, 0, 1, pat[k], 3'd0);
    chk("stream_done", done, 1'b1);
    chk("stream_word", out, 8'h4D);
    step(0, 0, 0, 0, 0, 3'd0);
    chk("done_one_cycle", done, 1'b0);

    // addressed writes
    step(0, 1, 0, 0, 0, 3'd0);
    step(0, 0, 1, 0, 1, 3'd5);
    step(0, 0, 1, 0, 1, 3'd0);
    chk("addr_word", out, 8'h21);
    for (int k = 0; k < 8; k++) step(0, 0, 1, 0, k[0], 3'(k));
    chk("addr_all_set", all_set, 1'b1);

    // collision at ptr=2
    step(0, 1, 0, 0, 0, 3'd0);
    step(0, 0, 0, 1, 0, 3'd0);
    step(0, 0, 0, 1, 0, 3'd0);
    step(0, 0, 1, 1, 1, 3'd6);
    chk("coll_bit6", out[6], 1'b1);
    chk("coll_bit2", out[2], 1'b0);
    chk("coll_ptr", ptr, 3'd2);
    chk("coll_err", err, 1'b1);
    step(0, 0, 0, 0, 0, 3'd0);

    // clr on the eighth shift suppresses done
    step(0, 1, 0, 0, 0, 3'd0);
    for (int k = 0; k < 7; k++) step(0, 0, 0, 1, 1, 3'd0);
    step(0, 1, 0, 1, 1, 3'd0);
    step(0, 0, 0, 0, 0, 3'd0);
    chk("clr8_out", out, 8'h00);

    // round trip: serialize every byte LSB first at full rate
    dones = 0;
    for (int val = 0; val < 256; val++) begin
      v = 8'(val);
      for (int k = 0; k < 8; k++) step(0, 0, 0, 1, v[k], 3'd0);
      if (done) dones++;
      chk("rt_word", out, v);
    end
    chk("rt_dones", dones, 256);

    // random traffic
    for (int i = 0; i < 1500; i++)
      step(($urandom % 97) == 0, ($urandom % 41) == 0, ($urandom % 4) == 0,
           ($urandom % 3) != 0, 1'($urandom), 3'($urandom));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
